// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: zeroing sweep after reset/init_req, then round-robin writeback grants.
// Grant is combinational (ready follows valid); the granted write reaches the RF one cycle later.
module rf_write_arbiter #(
  parameter int WD      = 32,
  parameter int SEL     = 5,
  parameter int NREQ    = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_req_i,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [NREQ*SEL-1:0] req_addr_i,
  input  logic [NREQ*WD-1:0]  req_data_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic                rf_we_o,
  output logic [SEL-1:0]      rf_waddr_o,
  output logic [WD-1:0]       rf_wdata_o,
  output logic                init_done_o
);

  localparam int IW = $clog2(NREQ);
  localparam logic [SEL-1:0] LAST_IDX = '1;

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q;
  logic [SEL-1:0]  idx_q;
  logic [IW-1:0]   rr_ptr_q;
  logic            rf_we_q;
  logic [SEL-1:0]  rf_waddr_q;
  logic [WD-1:0]   rf_wdata_q;
  logic            init_done_q;

  logic [NREQ-1:0] grant_d;
  logic [IW-1:0]   win_d;
  logic [IW-1:0]   cand_d;
  logic            hit_d;
  logic            xfer_d;
  logic [SEL-1:0]  win_addr_d;
  logic [WD-1:0]   win_data_d;
  logic            suppress_d;

  // Search begins just past the last winner so every requester gets a turn.
  always_comb begin
    hit_d   = 1'b0;
    win_d   = '0;
    cand_d  = '0;
    grant_d = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_d = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!hit_d && req_valid_i[cand_d]) begin
        hit_d = 1'b1;
        win_d = cand_d;
      end
    end
    if (state_q == RUN && !init_req_i && hit_d) grant_d[win_d] = 1'b1;
  end

  assign xfer_d     = |grant_d;
  assign win_addr_d = req_addr_i[int'(win_d)*SEL +: SEL];
  assign win_data_d = req_data_i[int'(win_d)*WD +: WD];
  assign suppress_d = ZERO_R0 && (win_addr_d == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          // The sweep writes r0 too, regardless of ZERO_R0.
          rf_we_q    <= 1'b1;
          rf_waddr_q <= idx_q;
          rf_wdata_q <= '0;
          if (idx_q == LAST_IDX) begin
            state_q     <= RUN;
            idx_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RUN: begin
          if (init_req_i) begin
            state_q     <= INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            rf_we_q     <= 1'b0;
          end else if (xfer_d) begin
            rr_ptr_q <= win_d;
            if (suppress_d) begin
              rf_we_q <= 1'b0;
            end else begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= win_addr_d;
              rf_wdata_q <= win_data_d;
            end
          end else begin
            rf_we_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign req_ready_o = grant_d;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: vector table, sweep/reset/re-init sequences and random traffic against a reference model.
module tb_rf_write_arbiter;

  localparam int WD = 32, SEL = 5, NREQ = 2, DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_req_i = 1'b0;
  logic [1:0]    req_valid_i = '0;
  logic [9:0]    req_addr_i = '0;
  logic [63:0]   req_data_i = '0;
  logic [1:0]    req_ready_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic          init_done_o;

  always #5 clk = ~clk;

  rf_write_arbiter #(.WD(WD), .SEL(SEL), .NREQ(NREQ), .ZERO_R0(1'b1)) dut (
    .clk(clk), .reset(rst), .init_req_i(init_req_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .init_done_o(init_done_o)
  );

  int n_cmp = 0, n_fail = 0;

  // Reference model: mode, sweep progress, last winner, pending RF write, RF contents.
  bit          m_run;
  int          m_cnt, m_last;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] sh_mem [DEPTH];
  logic [1:0]  got_ready;

  // Register file as seen by the RF: written from the DUT's write port.
  always @(posedge clk) if (!rst && rf_we_o) sh_mem[rf_waddr_o] <= rf_wdata_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_last = 0; m_we = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic ir);
    logic [1:0] exp_g;
    int w;
    logic [4:0] a;
    logic [31:0] d;
    req_valid_i = v; req_addr_i = {a1, a0}; req_data_i = {d1, d0}; init_req_i = ir;
    #1;
    exp_g = '0; w = -1;
    if (m_run && !ir)
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && v[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
    if (w >= 0) exp_g[w] = 1'b1;
    got_ready = req_ready_o;
    chk("ready", {30'd0, got_ready}, {30'd0, exp_g});
    @(posedge clk);
    if (m_we) m_mem[m_addr] = m_data;
    if (!m_run) begin
      m_we = 1; m_addr = 5'(m_cnt); m_data = '0; m_cnt++;
      if (m_cnt == DEPTH) begin m_run = 1; m_cnt = 0; end
    end else if (ir) begin
      m_run = 0; m_cnt = 0; m_we = 0;
    end else if (w >= 0) begin
      m_last = w;
      a = (w == 1) ? a1 : a0;
      d = (w == 1) ? d1 : d0;
      if (a == 5'd0) m_we = 0;
      else begin m_we = 1; m_addr = a; m_data = d; end
    end else begin
      m_we = 0;
    end
    #1;
    chk("rf_we", {31'd0, rf_we_o}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, m_addr});
    chk("rf_wdata", rf_wdata_o, m_data);
    chk("init_done", {31'd0, init_done_o}, {31'd0, m_run});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_we"}, {31'd0, rf_we_o}, 32'd0);
    chk({nm, "_waddr"}, {27'd0, rf_waddr_o}, 32'd0);
    chk({nm, "_wdata"}, rf_wdata_o, 32'd0);
    chk({nm, "_done"}, {31'd0, init_done_o}, 32'd0);
    chk({nm, "_ready"}, {30'd0, req_ready_o}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cnt;
    tbl[0] = '{2'b11, 5'd1, 5'd2,  32'h000000A1, 32'h000000B1, 2'b10, 1'b1, 5'd2,  32'h000000B1};
    tbl[1] = '{2'b11, 5'd4, 5'd5,  32'h000000A2, 32'h000000B2, 2'b01, 1'b1, 5'd4,  32'h000000A2};
    tbl[2] = '{2'b11, 5'd6, 5'd7,  32'h000000A3, 32'h000000B3, 2'b10, 1'b1, 5'd7,  32'h000000B3};
    tbl[3] = '{2'b11, 5'd8, 5'd9,  32'h000000A4, 32'h000000B4, 2'b01, 1'b1, 5'd8,  32'h000000A4};
    tbl[4] = '{2'b00, 5'd1, 5'd1,  32'h11111111, 32'h22222222, 2'b00, 1'b0, 5'd8,  32'h000000A4};
    tbl[5] = '{2'b01, 5'd3, 5'd10, 32'hDEADBEEF, 32'h33333333, 2'b01, 1'b1, 5'd3,  32'hDEADBEEF};
    tbl[6] = '{2'b01, 5'd9, 5'd10, 32'h11111111, 32'h33333333, 2'b01, 1'b1, 5'd9,  32'h11111111};
    tbl[7] = '{2'b10, 5'd9, 5'd0,  32'h44444444, 32'h00001234, 2'b10, 1'b0, 5'd9,  32'h11111111};
    tbl[8] = '{2'b10, 5'd9, 5'd31, 32'h44444444, 32'hCAFEF00D, 2'b10, 1'b1, 5'd31, 32'hCAFEF00D};
    tbl[9] = '{2'b00, 5'd9, 5'd31, 32'h44444444, 32'h55555555, 2'b00, 1'b0, 5'd31, 32'hCAFEF00D};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset state
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Zeroing sweep: 32 writes, then RUN
    idle(DEPTH);
    chk("sweep_last_addr", {27'd0, rf_waddr_o}, 32'd31);
    chk("sweep_done", {31'd0, init_done_o}, 32'd1);
    idle(1);
    chk("sweep_we_drop", {31'd0, rf_we_o}, 32'd0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("sweep_zero_r%0d", i), sh_mem[i], 32'd0);

    // Arbitration / write-latency vector table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, 1'b0);
      chk($sformatf("tbl%0d_ready", i), {30'd0, got_ready}, {30'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_we", i), {31'd0, rf_we_o}, {31'd0, tbl[i].we});
      chk($sformatf("tbl%0d_waddr", i), {27'd0, rf_waddr_o}, {27'd0, tbl[i].wa});
      chk($sformatf("tbl%0d_wdata", i), rf_wdata_o, tbl[i].wd);
    end
    chk("rd_r3", sh_mem[3], 32'hDEADBEEF);
    chk("rd_r0", sh_mem[0], 32'd0);
    chk("rd_r31", sh_mem[31], 32'hCAFEF00D);

    // init_req in RUN with req0 pending: no grant, full sweep, then grant
    step(2'b01, 5'd12, 5'd0, 32'h0BADF00D, 32'd0, 1'b1);
    chk("reinit_no_grant", {30'd0, got_ready}, 32'd0);
    cnt = 0;
    while (cnt < 40) begin
      step(2'b01, 5'd12, 5'd0, 32'h0BADF00D, 32'd0, 1'b0);
      if (got_ready != 2'b00) break;
      cnt++;
    end
    chk("reinit_sweep_len", cnt, 32'd32);
    chk("reinit_first_grant", {30'd0, got_ready}, 32'd1);
    idle(1);
    chk("reinit_r12", sh_mem[12], 32'h0BADF00D);

    // Reset in the middle of the sweep
    step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    idle(10);
    chk("midsweep_addr", {27'd0, rf_waddr_o}, 32'd9);
    rst = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(2'b11, 5'd1, 5'd2, 32'd1, 32'd2, 1'b0);
      if (init_done_o) break;
      cnt++;
    end
    chk("restart_sweep_len", cnt, 32'd31);

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      logic [4:0] ra0, ra1;
      ra0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      ra1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      step(2'($urandom), ra0, ra1, $urandom, $urandom, $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i < 40 && !m_run; i++) idle(1);
    idle(2);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("final_r%0d", i), sh_mem[i], m_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
